// File: rtl/result_mux12to1_stream.sv
// Collects twelve result lanes in one capture and streams them out one lane per
// accepted beat, tagging each beat with its 1..12 lane select code.
module result_mux12to1_stream #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_LANES = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W*N_LANES-1:0] lanes_in,
  input  logic                      load,
  output logic                      busy,
  output logic [DATA_W-1:0]         out_data,
  output logic [3:0]                out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done
);

  localparam logic [3:0] LAST_SEL = 4'(N_LANES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] bank [N_LANES];

  logic hs_c;
  logic final_c;
  logic capture_c;

  // A new frame is accepted when idle, or on the final beat for back-to-back frames.
  assign hs_c      = out_valid && out_ready;
  assign final_c   = hs_c && (out_sel == LAST_SEL);
  assign capture_c = load && ((state == IDLE) || final_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_data  <= '0;
      out_sel   <= 4'd0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < int'(N_LANES); k++) begin
        bank[k] <= '0;
      end
    end else begin
      done <= final_c;
      if (capture_c) begin
        for (int k = 0; k < int'(N_LANES); k++) begin
          bank[k] <= lanes_in[DATA_W*k +: DATA_W];
        end
        state     <= SEND;
        busy      <= 1'b1;
        out_valid <= 1'b1;
        out_sel   <= 4'd1;
        out_data  <= lanes_in[DATA_W-1:0];
      end else if (final_c) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_sel   <= 4'd0;
        out_data  <= '0;
      end else if (hs_c) begin
        // Tag k lives at bank[k-1], so the next lane is bank[current tag].
        out_sel  <= out_sel + 4'd1;
        out_data <= bank[out_sel];
      end
    end
  end

endmodule

// File: doc/result_mux12to1_stream.md
Name: result_mux12to1_stream

Overview:
Gathers twelve DATA_W-bit result lanes from the matrix multiplier in a single capture. Streams them out one lane per accepted beat over a valid/ready handshake. Each beat carries a 4-bit lane tag using the 1..12 select encoding of the lane demux, so a downstream demux or memory can route every beat. It is the collection/egress end of the matrix datapath, opposite the 1:12 lane distribution.

Parameters:
DATA_W, 8, width of one lane and of out_data.
N_LANES, 12, number of lanes. Fixed at 12; the tag encoding depends on it. Not intended to be overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
lanes_in  input  DATA_W*12  flat lane bus; lane k (1..12) occupies bits [DATA_W*k-1 : DATA_W*(k-1)].
load  input  1  capture request; sampled only when accepted (see Behaviour).
busy  output  1  high while a frame is being streamed; load is ignored when busy and not on the final beat.
out_data  output  DATA_W  current lane value.
out_sel  output  4  current lane tag, 4'd1..4'd12; 4'd0 when idle.
out_valid  output  1  out_data/out_sel valid.
out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
done  output  1  one-cycle pulse after lane 12 is accepted.

Behaviour:
- Reset, synchronous and dominant over all other inputs: state IDLE; out_data=0, out_sel=0, out_valid=0, busy=0, done=0; lane bank cleared to 0.
- Storage: 12 x DATA_W register bank. out_data and out_sel are registered outputs, not combinational from lanes_in.
- State IDLE:
  - load=1: capture all 12 lanes into the bank.
  - Next cycle: state SEND, out_valid=1, out_sel=1, out_data=lane1, busy=1.
  - Latency from load to first valid is 1 cycle.
  - load=0: all outputs hold their idle values.
- State SEND, no handshake (out_valid && !out_ready): out_data and out_sel hold stable; the bank is unchanged.
- State SEND, handshake with out_sel<12: out_sel increments by 1, out_data = bank[out_sel+1], out_valid stays 1.
- State SEND, handshake with out_sel==12 (final beat):
  - Next cycle done=1 for exactly one cycle.
  - If load=1 in that same cycle: capture the new frame; next cycle out_sel=1, out_data=new lane1, out_valid=1, busy=1 (back-to-back, no bubble).
  - Otherwise: state IDLE, out_valid=0, out_sel=0, busy=0, out_data=0.
- load during SEND on any cycle other than the final handshake: ignored. The bank is not overwritten and no frame is queued.
- Throughput: with out_ready held high, a frame takes exactly 12 consecutive beats. The tag sequence is 1,2,...,12 with no repeats or skips; tags 0 and 13..15 are never emitted while out_valid=1.
- out_ready while out_valid=0: no effect.
- Reset mid-frame: the frame is abandoned. Next cycle is IDLE per reset values. No done pulse is emitted for the abandoned frame.
- done and out_valid may be high in the same cycle only in the back-to-back case.

Test Plan:
- Reset then idle: assert rst 2 cycles with load=1 -> out_valid=0, out_sel=0, out_data=0, busy=0, done=0; no capture occurs.
- Basic frame: lane k = 8'h10+k, load 1 cycle, out_ready=1 -> 12 beats on consecutive cycles, (sel,data) = (1,11)...(12,1C); done pulses 1 cycle after beat 12; then idle.
- Backpressure: same frame, out_ready low for 3 cycles at sel=5 -> sel=5, data=15 held all 3 cycles; sequence resumes at 6; still exactly 12 accepted beats.
- Ignored load: during SEND at sel=3, pulse load with lanes_in all 8'hFF -> remaining beats still 13..1C; no second frame follows.
- Back-to-back: load frame B (lane k = 8'hA0+k) in the same cycle as the final frame-A handshake -> next cycle done=1, out_valid=1, sel=1, data=A1; no idle gap.
- Reset mid-frame: assert rst at sel=7 -> next cycle out_valid=0, sel=0, busy=0, no done; a subsequent load starts at sel=1 with the new data.
